// File: rtl/mips_pkg.sv
// Shared MIPS encodings: op enum, opcode (OP_*) and funct (OP0_*)
// constants, default load address and word-packing helpers.
package mips_pkg;

    typedef enum logic [4:0] {
        E_ADD  = 5'd0,
        E_SUB  = 5'd1,
        E_AND  = 5'd2,
        E_OR   = 5'd3,
        E_NOR  = 5'd4,
        E_XOR  = 5'd5,
        E_SLT  = 5'd6,
        E_JR   = 5'd7,
        E_ADDM = 5'd8,
        E_ADDI = 5'd9,
        E_ANDI = 5'd10,
        E_ORI  = 5'd11,
        E_XORI = 5'd12,
        E_LUI  = 5'd13,
        E_BEQ  = 5'd14,
        E_BNE  = 5'd15,
        E_J    = 5'd16,
        E_LW   = 5'd17,
        E_LBU  = 5'd18,
        E_SW   = 5'd19,
        E_SB   = 5'd20
    } op_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] OP0_JR   = 6'h08;
    localparam logic [5:0] OP0_ADD  = 6'h20;
    localparam logic [5:0] OP0_SUB  = 6'h22;
    localparam logic [5:0] OP0_AND  = 6'h24;
    localparam logic [5:0] OP0_OR   = 6'h25;
    localparam logic [5:0] OP0_XOR  = 6'h26;
    localparam logic [5:0] OP0_NOR  = 6'h27;
    localparam logic [5:0] OP0_SLT  = 6'h2A;
    localparam logic [5:0] OP0_ADDM = 6'h2C;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h0040_0000;

    function automatic logic [31:0] rtype(
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic [4:0] rd,
        input logic [5:0] funct
    );
        return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] itype(
        input logic [5:0]  opc,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [15:0] imm
    );
        return {opc, rs, rt, imm};
    endfunction

endpackage

// File: rtl/mips_encode_word.sv
// Combinational op/field -> 32-bit MIPS word packer with legality flag.
// MIPS_ADDM_EN: when defined, ADDM is legal (R-type funct 2Ch).
module mips_encode_word
    import mips_pkg::*;
(
    input  logic [4:0]  op_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] target_i,
    output logic [31:0] word_o,
    output logic        legal_o
);

    // Select format and code; unused fields are left as zero
    always_comb begin
        word_o  = '0;
        legal_o = 1'b1;
        case (op_i)
            E_ADD:  word_o = rtype(rs_i, rt_i, rd_i, OP0_ADD);
            E_SUB:  word_o = rtype(rs_i, rt_i, rd_i, OP0_SUB);
            E_AND:  word_o = rtype(rs_i, rt_i, rd_i, OP0_AND);
            E_OR:   word_o = rtype(rs_i, rt_i, rd_i, OP0_OR);
            E_NOR:  word_o = rtype(rs_i, rt_i, rd_i, OP0_NOR);
            E_XOR:  word_o = rtype(rs_i, rt_i, rd_i, OP0_XOR);
            E_SLT:  word_o = rtype(rs_i, rt_i, rd_i, OP0_SLT);
            E_JR:   word_o = rtype(rs_i, 5'd0, 5'd0, OP0_JR);
`ifdef MIPS_ADDM_EN
            E_ADDM: word_o = rtype(rs_i, rt_i, rd_i, OP0_ADDM);
`else
            E_ADDM: legal_o = 1'b0;
`endif
            E_ADDI: word_o = itype(OP_ADDI, rs_i, rt_i, imm_i);
            E_ANDI: word_o = itype(OP_ANDI, rs_i, rt_i, imm_i);
            E_ORI:  word_o = itype(OP_ORI, rs_i, rt_i, imm_i);
            E_XORI: word_o = itype(OP_XORI, rs_i, rt_i, imm_i);
            E_LUI:  word_o = itype(OP_LUI, 5'd0, rt_i, imm_i);
            E_BEQ:  word_o = itype(OP_BEQ, rs_i, rt_i, imm_i);
            E_BNE:  word_o = itype(OP_BNE, rs_i, rt_i, imm_i);
            E_J:    word_o = {OP_J, target_i};
            E_LW:   word_o = itype(OP_LW, rs_i, rt_i, imm_i);
            E_LBU:  word_o = itype(OP_LBU, rs_i, rt_i, imm_i);
            E_SW:   word_o = itype(OP_SW, rs_i, rt_i, imm_i);
            E_SB:   word_o = itype(OP_SB, rs_i, rt_i, imm_i);
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_encode.sv
// Streaming MIPS encoder: handshake in, word+address out via small FIFO.
// MIPS_ADDM_EN (see mips_encode_word) makes ADDM a legal request.
module mips_encode
    import mips_pkg::*;
#(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_op,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [15:0] in_imm,
    input  logic [25:0] in_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_addr,
    output logic        err,
    output logic [7:0]  err_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [31:0]   inst_q [DEPTH];
    logic [31:0]   addr_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   pc_q, pc_d;
    logic          err_q, err_d;
    logic [7:0]    errc_q, errc_d;

    logic [31:0] word;
    logic        legal;
    logic        full;
    logic        take;
    logic        push;
    logic        pop;

    mips_encode_word u_word (
        .op_i     (in_op),
        .rs_i     (in_rs),
        .rt_i     (in_rt),
        .rd_i     (in_rd),
        .imm_i    (in_imm),
        .target_i (in_target),
        .word_o   (word),
        .legal_o  (legal)
    );

    assign full      = (cnt_q == CW'(DEPTH));
    assign in_ready  = reset & ~flush & ~full;
    assign take      = in_valid & in_ready;
    assign push      = take & legal;
    assign out_valid = (cnt_q != '0);
    assign pop       = out_valid & out_ready;
    assign out_inst  = out_valid ? inst_q[rd_q] : 32'd0;
    assign out_addr  = out_valid ? addr_q[rd_q] : 32'd0;
    assign err       = err_q;
    assign err_count = errc_q;

    // Next-state for pointers, occupancy, address counter and error log
    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        pc_d   = pc_q;
        err_d  = take & ~legal;
        errc_d = errc_q;
        if (err_d && errc_q != 8'hFF) begin
            errc_d = errc_q + 8'd1;
        end
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
            pc_d  = BASE_ADDR;
        end else begin
            if (push) begin
                wr_d = wr_q + 1'b1;
                pc_d = pc_q + 32'd4;
            end
            if (pop) begin
                rd_d = rd_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Control state registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            pc_q   <= BASE_ADDR;
            err_q  <= 1'b0;
            errc_q <= 8'd0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            pc_q   <= pc_d;
            err_q  <= err_d;
            errc_q <= errc_d;
        end
    end

    // FIFO storage: word and its address written together on push
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i] <= 32'd0;
                addr_q[i] <= 32'd0;
            end
        end else if (push) begin
            inst_q[wr_q] <= word;
            addr_q[wr_q] <= pc_q;
        end
    end

endmodule

// File: tb/tb_mips_encode.sv
// Self-checking bench for mips_encode: vector table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_mips_encode;

    localparam int          DEPTH = 2;
    localparam logic [31:0] BASE  = 32'h0040_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_op = '0;
    logic [4:0]  in_rs = '0;
    logic [4:0]  in_rt = '0;
    logic [4:0]  in_rd = '0;
    logic [15:0] in_imm = '0;
    logic [25:0] in_target = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_addr;
    logic        err;
    logic [7:0]  err_count;

    mips_encode #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_imm    (in_imm),
        .in_target (in_target),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_addr  (out_addr),
        .err       (err),
        .err_count (err_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] w;
        logic [31:0] a;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc = BASE;
    bit          m_err = 0;
    int          m_cnt = 0;
    bit          s_rdy;

    typedef struct {
        int          op;
        int          rs;
        int          rt;
        int          rd;
        int          imm;
        int          tgt;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference encoder: {legal, word} from format and code tables
    function automatic logic [32:0] ref_enc(input int op, input int rs,
        input int rt, input int rd, input int imm, input int tgt);
        int unsigned code [0:20];
        longint w;
        bit ok;
        code = '{32, 34, 36, 37, 39, 38, 42, 8, 44,
                 8, 12, 13, 14, 15, 4, 5, 2, 35, 36, 43, 40};
        ok = (op >= 0 && op <= 20);
`ifndef MIPS_ADDM_EN
        if (op == 8) ok = 0;
`endif
        w = 0;
        if (ok) begin
            if (op <= 8) begin
                if (op == 7) w = rs * 2097152 + code[op];
                else w = rs * 2097152 + rt * 65536 + rd * 2048 + code[op];
            end else if (op == 16) begin
                w = 2 * 67108864 + tgt;
            end else begin
                w = code[op] * 67108864 + rt * 65536 + imm;
                if (op != 13) w = w + rs * 2097152;
            end
        end
        return {ok, w[31:0]};
    endfunction

    // One clock cycle: drive, sample/compare, then advance the model
    task automatic cyc(input bit v, input int op, input int rs,
        input int rt, input int rd, input int imm, input int tgt,
        input bit ordy, input bit fl);
        bit exp_rdy;
        bit acc;
        bit pp;
        logic [32:0] r;
        @(negedge clock);
        in_valid  = v;
        in_op     = 5'(op);
        in_rs     = 5'(rs);
        in_rt     = 5'(rt);
        in_rd     = 5'(rd);
        in_imm    = 16'(imm);
        in_target = 26'(tgt);
        out_ready = ordy;
        flush     = fl;
        #1;
        s_rdy   = in_ready;
        exp_rdy = reset && !fl && (mq.size() < DEPTH);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("out_inst", out_inst, mq[0].w);
            chk("out_addr", out_addr, mq[0].a);
        end
        chk("err", 32'(err), 32'(m_err));
        chk("err_count", 32'(err_count), 32'(m_cnt));
        acc = v && exp_rdy;
        pp  = (mq.size() != 0) && ordy;
        if (fl) begin
            mq.delete();
            m_pc  = BASE;
            m_err = 0;
        end else begin
            if (pp) void'(mq.pop_front());
            m_err = 0;
            if (acc) begin
                r = ref_enc(op, rs, rt, rd, imm, tgt);
                if (r[32]) begin
                    mq.push_back('{w: r[31:0], a: m_pc});
                    m_pc = m_pc + 32'd4;
                end else begin
                    m_err = 1;
                    if (m_cnt < 255) m_cnt++;
                end
            end
        end
    endtask

    task automatic idle(input bit ordy);
        cyc(0, 0, 0, 0, 0, 0, 0, ordy, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 8; i++) idle(1);
    endtask

    vec_t vt[$];

    initial begin
        vt.push_back('{0, 1, 2, 3, 0, 0, 32'h0022_1820});
        vt.push_back('{9, 4, 5, 0, 'hFFFF, 0, 32'h2085_FFFF});
        vt.push_back('{17, 29, 8, 0, 4, 0, 32'h8FA8_0004});
        vt.push_back('{16, 31, 31, 31, 'h1234, 'h010_0000, 32'h0810_0000});
        vt.push_back('{7, 9, 31, 31, 'hFFFF, 0, 32'h0120_0008});
        vt.push_back('{13, 31, 7, 0, 'h8000, 0, 32'h3C07_8000});

        // Reset state while reset is held low
        #1;
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst out_inst", out_inst, 0);
        chk("rst out_addr", out_addr, 0);
        chk("rst err", 32'(err), 0);
        chk("rst err_count", 32'(err_count), 0);
        chk("rst in_ready", 32'(in_ready), 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;

        // Table vectors: one request, word must show the next cycle
        foreach (vt[i]) begin
            cyc(1, vt[i].op, vt[i].rs, vt[i].rt, vt[i].rd,
                vt[i].imm, vt[i].tgt, 1, 0);
            idle(1);
            chk("vec valid", 32'(out_valid), 1);
            chk("vec inst", out_inst, vt[i].exp);
            chk("vec addr", out_addr, BASE + 32'(4 * i));
        end
        drain();

        // Backpressure: third request held until a pop frees space
        cyc(1, 0, 1, 2, 3, 0, 0, 0, 1);
        cyc(1, 0, 1, 2, 3, 0, 0, 0, 0);
        chk("bp rdy0", 32'(s_rdy), 1);
        cyc(1, 0, 1, 2, 4, 0, 0, 0, 0);
        chk("bp rdy1", 32'(s_rdy), 1);
        cyc(1, 0, 1, 2, 5, 0, 0, 0, 0);
        chk("bp full", 32'(s_rdy), 0);
        cyc(1, 0, 1, 2, 5, 0, 0, 1, 0);
        chk("bp pop no push", 32'(s_rdy), 0);
        cyc(1, 0, 1, 2, 5, 0, 0, 0, 0);
        chk("bp resume", 32'(s_rdy), 1);
        chk("bp addr1", out_addr, BASE + 32'd4);
        drain();

        // Illegal op 25 then ADDM
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 1);
        cyc(1, 25, 1, 2, 3, 0, 0, 1, 0);
        idle(1);
        chk("ill err", 32'(err), 1);
        chk("ill cnt", 32'(err_count), 1);
        chk("ill noout", 32'(out_valid), 0);
        idle(1);
        chk("ill pulse end", 32'(err), 0);
        cyc(1, 8, 1, 2, 3, 0, 0, 1, 0);
        idle(1);
`ifdef MIPS_ADDM_EN
        chk("addm inst", out_inst, 32'h0022_182C);
        chk("addm cnt", 32'(err_count), 1);
`else
        chk("addm err", 32'(err), 1);
        chk("addm cnt", 32'(err_count), 2);
`endif
        drain();
        cyc(1, 21, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 31, 0, 0, 0, 0, 0, 1, 0);
        chk("b2b err1", 32'(err), 1);
        idle(1);
        chk("b2b err2", 32'(err), 1);
        idle(1);
        chk("b2b err3", 32'(err), 0);

        // Flush with two words queued
        cyc(1, 1, 1, 2, 3, 0, 0, 0, 0);
        cyc(1, 2, 4, 5, 6, 0, 0, 0, 0);
        cyc(1, 0, 1, 2, 3, 0, 0, 0, 1);
        chk("flush refuse", 32'(s_rdy), 0);
        idle(0);
        chk("flush empty", 32'(out_valid), 0);
        cyc(1, 0, 1, 2, 3, 0, 0, 1, 0);
        idle(1);
        chk("flush addr", out_addr, BASE);
        chk("flush inst", out_inst, 32'h0022_1820);
        drain();

        // Asynchronous reset with words queued
        cyc(1, 0, 1, 2, 3, 0, 0, 0, 0);
        cyc(1, 3, 1, 2, 3, 0, 0, 0, 0);
        @(negedge clock);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("arst valid", 32'(out_valid), 0);
        chk("arst ready", 32'(in_ready), 0);
        chk("arst inst", out_inst, 0);
        chk("arst cnt", 32'(err_count), 0);
        mq.delete();
        m_pc  = BASE;
        m_err = 0;
        m_cnt = 0;
        @(negedge clock);
        reset = 1'b1;
        idle(1);

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            int op;
            op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(21, 31))
                                             : int'($urandom_range(0, 20));
            cyc($urandom_range(0, 9) < 7, op,
                $urandom_range(0, 31), $urandom_range(0, 31),
                $urandom_range(0, 31), $urandom_range(0, 65535),
                $urandom_range(0, 67108863),
                $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
        end
        drain();

        // err_count saturation
        for (int n = 0; n < 270; n++) cyc(1, 31, 0, 0, 0, 0, 0, 1, 0);
        idle(1);
        chk("err sat", 32'(err_count), 255);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
